// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - multi-cycle logical right shifter with programmable fill bit
//
// Purpose:
//   Shifts operand A right by min(B, BW) positions, one position per clock,
//   inserting the captured fill bit Fin at the MSB on every shift. The result
//   Y and the last bit shifted out E are registered on entry to DONE and held
//   until the next result or reset.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request a new shift; ignored while busy
//   A      in   BW  operand
//   B      in   BW  unsigned shift amount
//   Fin    in   1   fill bit inserted at the MSB
//   busy   out  1   high while shifting
//   done   out  1   one-cycle pulse while the result is being presented
//   Y      out  BW  registered shift result
//   E      out  1   registered last bit shifted out

module shift_right_seq #(
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic          Fin,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] Y,
  output logic          E
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to hold BW itself.
  localparam int CW = $clog2(BW + 1);
  // Wide enough for both B and the constant BW, so the clamp compare is exact.
  localparam int XW = (BW > CW) ? BW : CW;

  localparam logic [CW-1:0] BW_CNT  = CW'(BW);
  localparam logic [XW-1:0] BW_WIDE = XW'(BW);

  state_t        state_q, state_d;
  logic [BW-1:0] work_q,  work_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          fin_q,   fin_d;
  logic          over_q,  over_d;
  logic [BW-1:0] y_q,     y_d;
  logic          e_q,     e_d;

  logic [XW-1:0] b_wide;
  logic          b_over;
  logic [CW-1:0] n_cnt;
  logic [BW-1:0] work_shifted;

  // Shift count N = min(B, BW). When B exceeds BW every original bit is pushed
  // out, so E must report the fill bit rather than A[BW-1]; remember that case.
  assign b_wide = XW'(B);
  assign b_over = (b_wide > BW_WIDE);
  assign n_cnt  = b_over ? BW_CNT : CW'(B);

  generate
    if (BW == 1) begin : g_shift_narrow
      assign work_shifted = fin_q;
    end else begin : g_shift_wide
      assign work_shifted = {fin_q, work_q[BW-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    over_d  = over_q;
    y_d     = y_q;
    e_d     = e_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          fin_d  = Fin;
          over_d = b_over;
          work_d = A;
          if (n_cnt != '0) begin
            state_d = SHIFT;
            cnt_d   = n_cnt;
          end else begin
            // Zero-length shift: result is available immediately.
            state_d = DONE;
            cnt_d   = '0;
            y_d     = A;
            e_d     = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // start is deliberately not looked at here.
        work_d = work_shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          y_d     = work_shifted;
          e_d     = over_q ? fin_q : work_q[0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      over_q  <= 1'b0;
      y_q     <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      over_q  <= over_d;
      y_q     <= y_d;
      e_q     <= e_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign Y    = y_q;
  assign E    = e_q;

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL have parameter BW, default 4, giving the operand and result width in bits.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new shift; sampled only when not busy.
REQ-006 SHALL have port A, input, BW bits: the operand to be shifted right.
REQ-007 SHALL have port B, input, BW bits: the unsigned shift amount.
REQ-008 SHALL have port Fin, input, 1 bit: the fill bit inserted at the MSB on each shift.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port Y, output, BW bits: the registered shift result.
REQ-012 SHALL have port E, output, 1 bit: the registered last bit shifted out.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL capture A, B and Fin on the edge where start=1 while in IDLE or DONE, with no other operand sampling.
REQ-015 SHALL define the shift count N = min(B, BW).
- On capture with N>0: go to SHIFT and load the working register with A and the counter with N.
- On capture with N=0: go directly to DONE.
REQ-016 SHALL, on each SHIFT edge:
- set work = {Fin_cap, work[BW-1:1]};
- set the shift-out bit to work[0];
- decrement the counter;
- go to DONE on the edge where the counter goes from 1 to 0.
REQ-017 SHALL update Y and E on the edge of entry to DONE and hold them until the next DONE entry or reset.
REQ-018 SHALL produce Y = A shifted right logically by N, with the vacated MSBs equal to Fin_cap.
REQ-019 SHALL produce E according to B:
- B=0: E=0.
- 1<=B<=BW: E = A[B-1].
- B>BW: E = Fin_cap, and Y = all Fin_cap.
REQ-020 SHALL have latency such that, if start is sampled at edge 0, done=1 in cycle N+1 and for exactly one cycle.
REQ-021 SHALL drive busy=1 exactly while in SHIFT, and drive done=1 exactly while in DONE.
REQ-022 SHALL ignore start while in SHIFT, leaving operands and progress unaffected.
REQ-023 SHALL, in DONE, go to SHIFT (or re-enter DONE when N=0) if start=1, and otherwise go to IDLE.
- Back-to-back operations are therefore supported with no idle cycle.
REQ-024 SHALL keep Y and E stable throughout SHIFT, holding the previous result.
REQ-025 SHALL keep input changes after capture without effect on the current operation.

Reset
REQ-026 SHALL, on any edge with rst_n=0, force:
- state=IDLE;
- Y=0, E=0, busy=0, done=0;
- counter=0 and working register=0.
REQ-027 SHALL let reset take priority over start and abort any operation mid-SHIFT with no done pulse.
REQ-028 SHALL accept start at the first edge with rst_n=1.

Verification (BW=4, start pulsed at cycle 0)
REQ-029 SHALL cover: A=1011, B=1, Fin=0 -> cycle 2: done=1, Y=0101, E=1; busy=1 in cycle 1 only.
REQ-030 SHALL cover: A=1011, B=2, Fin=1 -> cycle 3: done=1, Y=1110, E=1.
REQ-031 SHALL cover: A=0110, B=0, Fin=1 -> cycle 1: done=1, Y=0110, E=0; busy never high.
REQ-032 SHALL cover: A=0101, B=7, Fin=1 -> cycle 5: done=1, Y=1111, E=1; the same A with B=4, Fin=0 gives Y=0000, E=0.
REQ-033 SHALL cover: A=1000, B=3, then start re-pulsed in cycle 2 with A=0001 -> re-pulse ignored; cycle 4: Y=0001, E=0.
REQ-034 SHALL cover: A=1111, B=4, then rst_n=0 in cycle 2 -> cycle 3: Y=0, E=0, busy=0, done=0; no done pulse follows.
